// File: rtl/counter_seq_checker.sv
// Receive-side monitor for a free-running modulo-2^WIDTH up-counter stream.
// Acquires lock on a run of correct increments, then flywheels and counts errors.
module counter_seq_checker #(
  parameter int WIDTH         = 4,
  parameter int LOCK_COUNT    = 4,
  parameter int LOSS_COUNT    = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  input  logic                     clear,
  output logic                     locked,
  output logic                     err_pulse,
  output logic                     wrap_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int BW = (LOSS_COUNT < 1) ? 1 : $clog2(LOSS_COUNT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, SLIP} state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         ref_q, ref_d;
  logic [GW-1:0]            good_q, good_d;
  logic [BW-1:0]            bad_q, bad_d;
  logic                     err_d, wrap_d, locked_d;
  logic [ERR_CNT_WIDTH-1:0] errc_d;

  logic [WIDTH-1:0] expect_val;
  logic [GW-1:0]    good_inc;
  logic [BW-1:0]    bad_inc;
  logic             hit;

  assign expect_val = ref_q + WIDTH'(1);
  assign hit        = (din == expect_val);
  assign good_inc   = good_q + GW'(1);
  assign bad_inc    = bad_q + BW'(1);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        IDLE: begin
          ref_d   = din;
          good_d  = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          // Re-anchor on every sample so a stream jump restarts the run cleanly.
          ref_d = din;
          if (hit) begin
            if (good_inc == GOOD_LAST) begin
              state_d = LOCKED;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_inc;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED, SLIP: begin
          // Flywheel: the reference advances whether or not din agrees,
          // so a single corrupt sample costs exactly one error.
          ref_d = expect_val;
          if (hit) begin
            state_d = LOCKED;
            bad_d   = '0;
            wrap_d  = (din == '0);
          end else begin
            err_d = 1'b1;
            bad_d = bad_inc;
            if (bad_inc == BAD_LAST) begin
              state_d = ACQUIRE;
              good_d  = '0;
              ref_d   = din;
            end else begin
              state_d = SLIP;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    errc_d = err_count;
    if (clear)
      errc_d = '0;
    else if (err_d && (err_count != '1))
      errc_d = err_count + ERR_CNT_WIDTH'(1);
  end

  assign locked_d = (state_d == LOCKED) || (state_d == SLIP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ref_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      locked     <= locked_d;
      err_pulse  <= err_d;
      wrap_pulse <= wrap_d;
      err_count  <= errc_d;
    end
  end

endmodule
